// File: rtl/round_sat_pipe_pkg.sv
// round_sat_pipe_pkg
// Shared definitions for the round/saturate pipeline: the rounding-mode
// encoding carried with each beat and the width of the optional
// saturation-event counter.
// Optional feature macro used by the top: ROUND_SAT_CNT_EN.
package round_sat_pipe_pkg;

    // Rounding-mode encoding. Code 11 behaves exactly like RND_HALF_AWAY.
    typedef enum logic [1:0] {
        RND_FLOOR         = 2'b00,
        RND_HALF_AWAY     = 2'b01,
        RND_HALF_EVEN     = 2'b10,
        RND_HALF_AWAY_ALT = 2'b11
    } rnd_mode_t;

    localparam int SAT_CNT_W = 16;

endpackage

// File: rtl/round_sat_lane.sv
// round_sat_lane
// Single-lane combinational datapath, split into two independent halves so
// the top can place a pipeline register between them:
//   round half    : i_x, i_mode -> o_rnd (value >> FRAC_W after rounding,
//                   kept at full IN_W+1-FRAC_W width so nothing is lost)
//   saturate half : i_rnd -> o_y (clamped to OUT_W signed), o_sat (clamped)
// Ports:
//   i_x    [IN_W-1:0]        signed input sample
//   i_mode [1:0]             rounding mode (rnd_mode_t encoding)
//   o_rnd  [IN_W-FRAC_W:0]   rounded value, signed
//   i_rnd  [IN_W-FRAC_W:0]   rounded value to saturate (registered upstream)
//   o_y    [OUT_W-1:0]       saturated output
//   o_sat                    1 when o_y was clamped
module round_sat_lane
    import round_sat_pipe_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16
) (
    input  logic [IN_W-1:0]     i_x,
    input  logic [1:0]          i_mode,
    output logic [IN_W-FRAC_W:0] o_rnd,
    input  logic [IN_W-FRAC_W:0] i_rnd,
    output logic [OUT_W-1:0]    o_y,
    output logic                o_sat
);

    localparam int RND_W = IN_W + 1 - FRAC_W;

    // ---------------- rounding ----------------
    // One extra bit of headroom so adding the rounding constant to the
    // most positive input cannot wrap.
    logic [IN_W:0] w_ext;
    logic [IN_W:0] w_sum;

    assign w_ext = {i_x[IN_W-1], i_x};

    generate
        if (FRAC_W == 0) begin : g_nofrac
            logic w_unused_mode;
            assign w_unused_mode = ^i_mode;
            assign w_sum = w_ext;
        end else begin : g_frac
            localparam logic [IN_W:0] ONE     = {{IN_W{1'b0}}, 1'b1};
            localparam logic [IN_W:0] HALF    = ONE << (FRAC_W - 1);
            localparam logic [IN_W:0] HALF_M1 = HALF - ONE;

            logic [IN_W:0] w_addend;

            always_comb begin
                w_addend = '0;
                case (i_mode)
                    RND_FLOOR:     w_addend = '0;
                    // Adding just under one half then flooring rounds an
                    // exact half up only when the retained LSB is odd.
                    RND_HALF_EVEN: w_addend = HALF_M1 + {{IN_W{1'b0}}, i_x[FRAC_W]};
                    // Negative values use half-1 so an exact half floors
                    // further from zero, mirroring the positive side.
                    default:       w_addend = i_x[IN_W-1] ? HALF_M1 : HALF;
                endcase
            end

            assign w_sum = w_ext + w_addend;
        end
    endgenerate

    // Arithmetic shift right by FRAC_W followed by truncation to RND_W bits
    // is simply the upper slice of the sum.
    assign o_rnd = w_sum[IN_W:FRAC_W];

    // ---------------- saturation ----------------
    // The value fits in OUT_W bits iff every bit from the OUT_W-1 position
    // upward equals the sign bit.
    logic [RND_W-OUT_W:0] w_top;
    logic                 w_fits;

    assign w_top  = i_rnd[RND_W-1:OUT_W-1];
    assign w_fits = (&w_top) | ~(|w_top);

    always_comb begin
        o_y   = i_rnd[OUT_W-1:0];
        o_sat = 1'b0;
        if (!w_fits) begin
            o_sat = 1'b1;
            if (i_rnd[RND_W-1]) begin
                o_y = {1'b1, {(OUT_W-1){1'b0}}};
            end else begin
                o_y = {1'b0, {(OUT_W-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/round_sat_pipe.sv
// round_sat_pipe
// Multi-lane round-then-saturate pipeline with valid/ready handshakes on
// both sides. Stage S1 holds the rounded (mode already applied) lanes,
// stage S2 holds the saturated output. Latency is two cycles; throughput is
// one beat per cycle while out_ready is high. Bubbles collapse: an empty
// stage always accepts from upstream.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake (in_ready depends on out_ready)
//   in_data [LANES*IN_W]  lane k at [k*IN_W +: IN_W]
//   in_mode [2]           rounding mode, travels with the beat
//   out_valid/out_ready   output handshake
//   out_data [LANES*OUT_W], out_sat [LANES]   result lanes and clamp flags
// Optional (macro ROUND_SAT_CNT_EN):
//   sat_clr  in   synchronous clear of sat_cnt (wins over increment)
//   sat_cnt  out  16-bit saturating count of transferred beats with any
//                 out_sat bit set
module round_sat_pipe
    import round_sat_pipe_pkg::*;
#(
    parameter int IN_W   = 32,
    parameter int FRAC_W = 8,
    parameter int OUT_W  = 16,
    parameter int LANES  = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat
`ifdef ROUND_SAT_CNT_EN
    ,
    input  logic                   sat_clr,
    output logic [SAT_CNT_W-1:0]   sat_cnt
`endif
);

    localparam int RND_W = IN_W + 1 - FRAC_W;

    logic                   r_s1_valid;
    logic [LANES*RND_W-1:0] r_s1_rnd;
    logic                   r_s2_valid;
    logic [LANES*OUT_W-1:0] r_s2_data;
    logic [LANES-1:0]       r_s2_sat;

    logic [LANES*RND_W-1:0] w_s1_rnd;
    logic [LANES*OUT_W-1:0] w_s2_data;
    logic [LANES-1:0]       w_s2_sat;
    logic                   w_s1_adv;
    logic                   w_s2_adv;

    // A stage advances when it is empty or its content leaves this cycle.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;

    assign in_ready  = w_s1_adv;
    assign out_valid = r_s2_valid;
    assign out_data  = r_s2_data;
    assign out_sat   = r_s2_sat;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            round_sat_lane #(
                .IN_W   (IN_W),
                .FRAC_W (FRAC_W),
                .OUT_W  (OUT_W)
            ) u_lane (
                .i_x    (in_data[gi*IN_W +: IN_W]),
                .i_mode (in_mode),
                .o_rnd  (w_s1_rnd[gi*RND_W +: RND_W]),
                .i_rnd  (r_s1_rnd[gi*RND_W +: RND_W]),
                .o_y    (w_s2_data[gi*OUT_W +: OUT_W]),
                .o_sat  (w_s2_sat[gi])
            );
        end
    endgenerate

    // Stage S1: rounded lanes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_rnd   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_rnd <= w_s1_rnd;
            end
        end
    end

    // Stage S2: saturated output; held untouched while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_sat   <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_data <= w_s2_data;
                r_s2_sat  <= w_s2_sat;
            end
        end
    end

`ifdef ROUND_SAT_CNT_EN
    logic [SAT_CNT_W-1:0] r_sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (sat_clr) begin
            r_sat_cnt <= '0;
        end else if (r_s2_valid && out_ready && (|r_s2_sat) && !(&r_sat_cnt)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

endmodule

// File: tb/tb_round_sat_pipe.sv
module tb_round_sat_pipe;

    localparam int IN_W   = 32;
    localparam int FRAC_W = 8;
    localparam int OUT_W  = 16;
    localparam int LANES  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*IN_W-1:0]  in_data;
    logic [1:0]             in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*OUT_W-1:0] out_data;
    logic [LANES-1:0]       out_sat;
`ifdef ROUND_SAT_CNT_EN
    logic                   sat_clr;
    logic [15:0]            sat_cnt;
`endif

    round_sat_pipe #(
        .IN_W(IN_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W), .LANES(LANES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef ROUND_SAT_CNT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [LANES*OUT_W-1:0] d;
        logic [LANES-1:0]       s;
    } beat_t;

    beat_t exp_q[$];

    // Reference: exact floor quotient and remainder, then decide rounding
    // from the remainder, then clamp.
    function automatic void model_lane(input logic [31:0] x, input logic [1:0] mode,
                                       output logic [15:0] y, output logic s);
        longint v, q, r, half;
        v    = longint'($signed(x));
        q    = v >>> FRAC_W;
        r    = v - q * (longint'(1) << FRAC_W);
        half = longint'(1) << (FRAC_W - 1);
        if (mode == 2'b10) begin
            if (r > half || (r == half && q[0])) q = q + 1;
        end else if (mode != 2'b00) begin
            if (r > half || (r == half && v >= 0)) q = q + 1;
        end
        if (q > 32767) begin
            y = 16'h7FFF; s = 1'b1;
        end else if (q < -32768) begin
            y = 16'h8000; s = 1'b1;
        end else begin
            y = q[15:0]; s = 1'b0;
        end
    endfunction

    function automatic beat_t model_beat(input logic [LANES*IN_W-1:0] d, input logic [1:0] m);
        beat_t b;
        logic [15:0] y;
        logic s;
        for (int k = 0; k < LANES; k++) begin
            model_lane(d[k*IN_W +: IN_W], m, y, s);
            b.d[k*OUT_W +: OUT_W] = y;
            b.s[k] = s;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare process: evaluated on the falling edge, describing the
    // transfers that the next rising edge will perform.
    logic  hold_v = 1'b0;
    beat_t hold_b;
    beat_t mon_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("held_valid", out_valid, 1'b1);
                chk("held_data", {out_data, out_sat}, hold_b);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("out_data", out_data, mon_e.d);
                    chk("out_sat", out_sat, mon_e.s);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_b = '{d: out_data, s: out_sat};
            if (in_valid && in_ready) exp_q.push_back(model_beat(in_data, in_mode));
        end
    end

    // One beat through an empty pipe with out_ready high; checks latency
    // and a hand-computed literal on every lane.
    task automatic send1(input logic [31:0] x, input logic [1:0] m,
                         input logic [15:0] ey, input logic es, input string name);
        @(posedge clk); #1;
        in_data  = {LANES{x}};
        in_mode  = m;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({name, "_early"}, out_valid, 1'b0);
        @(posedge clk); #1;
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_data"}, out_data, {LANES{ey}});
        chk({name, "_sat"}, out_sat, {LANES{es}});
        $display("beat %s x=%h mode=%0d -> %h sat=%b", name, x, m, out_data[15:0], out_sat[0]);
    endtask

    int seq;
    logic acc;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = 2'b00;
        out_ready = 1'b1;
`ifdef ROUND_SAT_CNT_EN
        sat_clr   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_sat", out_sat, '0);
`ifdef ROUND_SAT_CNT_EN
        chk("rst_sat_cnt", sat_cnt, 16'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("ready_after_reset", in_ready, 1'b1);

        // Directed rounding / saturation literals.
        send1(32'h00000280, 2'b00, 16'h0002, 1'b0, "p2p5_floor");
        send1(32'h00000280, 2'b01, 16'h0003, 1'b0, "p2p5_away");
        send1(32'h00000280, 2'b10, 16'h0002, 1'b0, "p2p5_even");
        send1(32'h00000380, 2'b10, 16'h0004, 1'b0, "p3p5_even");
        send1(32'hFFFFFD80, 2'b00, 16'hFFFD, 1'b0, "m2p5_floor");
        send1(32'hFFFFFD80, 2'b01, 16'hFFFD, 1'b0, "m2p5_away");
        send1(32'hFFFFFD80, 2'b10, 16'hFFFE, 1'b0, "m2p5_even");
        send1(32'hFFFFFD80, 2'b11, 16'hFFFD, 1'b0, "m2p5_mode3");
        send1(32'h7FFFFFFF, 2'b01, 16'h7FFF, 1'b1, "max_sat");
        send1(32'h80000000, 2'b00, 16'h8000, 1'b1, "min_sat");
        send1(32'h007FFF00, 2'b00, 16'h7FFF, 1'b0, "edge_nosat");

        // Continuous stream with a 5-cycle stall.
        @(posedge clk); #1;
        seq      = 0;
        in_mode  = 2'b01;
        in_valid = 1'b1;
        in_data  = {LANES{32'(seq << FRAC_W)}};
        for (int c = 0; c < 22; c++) begin
            out_ready = !(c >= 6 && c < 11);
            @(negedge clk); #1;
            acc = in_ready;
            if (c == 10) begin
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_out_valid", out_valid, 1'b1);
                chk("stall_held_beats", 32'(exp_q.size()), 32'd2);
            end
            if (c >= 12) begin
                chk("resume_in_ready", in_ready, 1'b1);
                chk("resume_out_valid", out_valid, 1'b1);
            end
            @(posedge clk); #1;
            if (acc) begin
                seq++;
                in_data = {LANES{32'(seq << FRAC_W)}};
            end
        end
        $display("stream accepted %0d beats", seq);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);

        // Reset with two beats in flight.
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = {LANES{32'h00001234}};
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre_reset_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 1'b0);
        chk("async_reset_data", out_data, '0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        chk("post_reset_empty", out_valid, 1'b0);
        @(negedge clk); #1;
        chk("post_reset_ready", in_ready, 1'b1);
        send1(32'h00000280, 2'b01, 16'h0003, 1'b0, "after_reset");

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_mode   = 2'($urandom_range(3));
            for (int k = 0; k < LANES; k++) begin
                if ($urandom_range(3) == 0)
                    in_data[k*IN_W +: IN_W] = $urandom;
                else
                    in_data[k*IN_W +: IN_W] = 32'($signed(24'($urandom)));
            end
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

`ifdef ROUND_SAT_CNT_EN
        @(posedge clk); #1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("cnt_cleared", sat_cnt, 16'd0);
        send1(32'h7FFFFFFF, 2'b00, 16'h7FFF, 1'b1, "cnt_a");
        send1(32'h80000000, 2'b00, 16'h8000, 1'b1, "cnt_b");
        send1(32'h7FFFFFFF, 2'b10, 16'h7FFF, 1'b1, "cnt_c");
        @(posedge clk); #1;
        chk("cnt_three", sat_cnt, 16'd3);
        in_data  = {LANES{32'h7FFFFFFF}};
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        chk("cnt_clear_wins", sat_cnt, 16'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
